bin_to_gray_counter: RTL and testbench
======================================

# bin_to_gray_counter

Registered N-bit up-counter that keeps a binary count and a Gray-coded copy of it. This is the encoding counterpart of the team's Gray-to-binary converter. The Gray output moves by exactly one bit per increment, so it can be sampled safely in another clock domain, for example as an async-FIFO write/read pointer. Downstream, `grayToBin` recovers the binary value.

## Interface
- `N`, default 4, counter and code width in bits (N ≥ 2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous reset, active-high
- `en`  input  1  count enable; increment by one when high
- `clr`  input  1  synchronous clear to zero
- `load`  input  1  synchronous load of `load_val`
- `load_val`  input  N  binary value to load
- `bin_out`  output  N  registered binary count
- `gray_out`  output  N  registered Gray code of `bin_out`
- `wrap`  output  1  registered one-cycle pulse on increment-overflow

## Operation
- Gray rule: `gray = b ^ (b >> 1)`, so `gray[N-1] = b[N-1]` and `gray[i] = b[i+1] ^ b[i]`.
- `gray_out` comes straight from a flop. It is loaded with the Gray encoding of the next binary value, never decoded combinationally after the register.
- Next-state priority on each rising edge, highest first:
  - `clr`=1: binary ← 0, gray ← 0, wrap ← 0.
  - else `load`=1: binary ← `load_val`, gray ← encode(`load_val`), wrap ← 0.
  - else `en`=1: binary ← binary + 1 modulo 2^N, gray ← encode(binary + 1), wrap ← (binary == 2^N−1).
  - else: binary and gray hold, wrap ← 0.
- Arithmetic is N bits wide. The carry out of the increment is dropped, and overflow shows only on `wrap`.
- Invariant, checked every cycle after reset: `gray_out == bin_out ^ (bin_out >> 1)`.
- On increments, exactly one bit of `gray_out` changes, including the wrap from 2^N−1 to 0 (Gray 100…0 → 000…0).
- `load` and `clr` may change several Gray bits in one cycle. This is permitted, and users must not apply them while another domain is sampling.

## Timing
- Asynchronous reset: while `rst`=1, the following hold immediately, with no clock needed, and stay until `rst` falls:
  - `bin_out`=0
  - `gray_out`=0
  - `wrap`=0
- First count edge: the first rising edge with `rst`=0 and `en`=1 gives `bin_out`=1.
- Latency: one cycle. Inputs sampled at edge k appear on all outputs after edge k. `bin_out`, `gray_out` and `wrap` always update on the same edge.
- `wrap`: high for exactly the one cycle after the edge that moved 2^N−1 → 0. Continuous `en` gives one pulse every 2^N cycles.
- Simultaneous controls:
  - `clr` with `load` and/or `en`: clear wins.
  - `load` with `en`: the load value is taken, with no extra increment.
  - `load` of 0 from 2^N−1 does not assert `wrap`.
- Reset mid-operation: asserting `rst` at any time discards the count and `wrap` asynchronously. Counting restarts from 0.
- No combinational path exists from any input to any output.

## Test plan
- Reset: hold `rst`=1 with `en`=1 for 3 cycles, then release → `bin_out`=0, `gray_out`=0, `wrap`=0 throughout; the first edge after release gives `bin_out`=1, `gray_out`=0001.
- Full sequence (N=4): `en`=1 for 16 cycles from 0 → `gray_out` follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. Each step has Hamming distance 1, and the invariant holds every cycle.
- Wrap and hold:
  - At 15 with `en`=1 → `bin_out`=0, `gray_out`=0000, `wrap`=1 for one cycle only.
  - `en`=0 for 5 cycles → outputs frozen, `wrap`=0.
- Load: `load`=1, `load_val`=0101 with `en`=1 → `bin_out`=0101, `gray_out`=0111, no extra increment; the next `en` cycle gives 0110 / 0101.
- Priority: from 7, apply `clr`=`load`=`en`=1 with `load_val`=1010 → `bin_out`=0, `gray_out`=0, `wrap`=0.
- Async reset mid-count: assert `rst` between clock edges at count 9 → outputs go to 0 before the next edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// bin_to_gray_counter: registered N-bit up-counter that carries a binary count
// and a flop-sourced Gray copy of it. The Gray copy is suitable for sampling
// in another clock domain, for example as an async-FIFO pointer.
// Control priority: clr > load > en > hold. wrap pulses for one cycle
// after an increment that takes the count from all-ones to zero.
module bin_to_gray_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         wrap
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] bin_q,  bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] bin_inc;

    function automatic logic [N-1:0] encode(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray is encoded from the next binary value so it leaves a flop directly.
    always_comb begin
        bin_d   = bin_q;
        gray_d  = gray_q;
        wrap_d  = 1'b0;
        bin_inc = bin_q + ONE;
        if (clr) begin
            bin_d  = '0;
            gray_d = '0;
        end else if (load) begin
            bin_d  = load_val;
            gray_d = encode(load_val);
        end else if (en) begin
            bin_d  = bin_inc;
            gray_d = encode(bin_inc);
            wrap_d = (bin_q == '1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Scoreboard bench for bin_to_gray_counter (N=4). A stimulus process drives
// inputs on the falling edge and queues the expected post-edge state from a
// count-based reference model; a monitor pops and compares after each rising edge.
module tb_bin_to_gray_counter;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] bin;
        logic [N-1:0] gray;
        logic         wrap;
        bit           inc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en, clr, load;
    logic [N-1:0] load_val;
    logic [N-1:0] bin_out, gray_out;
    logic         wrap;

    int assertions = 0;
    int failures   = 0;

    exp_t sb_q[$];

    // Reference: integer count modulo 16 and the published Gray sequence.
    logic [N-1:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    int m_cnt  = 0;
    bit m_wrap = 0;

    bin_to_gray_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        assertions++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the model advances as the DUT will at the next rising edge.
    task automatic step(input bit r, input bit e, input bit c, input bit l, input int lv);
        exp_t x;
        bit   inc;
        @(negedge clk);
        rst = r; en = e; clr = c; load = l; load_val = lv[N-1:0];
        inc = 0;
        if (r || c) begin
            m_cnt = 0; m_wrap = 0;
        end else if (l) begin
            m_cnt = lv % 16; m_wrap = 0;
        end else if (e) begin
            m_wrap = (m_cnt == 15);
            m_cnt  = (m_cnt + 1) % 16;
            inc    = 1;
        end else begin
            m_wrap = 0;
        end
        x.bin = m_cnt[N-1:0]; x.gray = gtab[m_cnt]; x.wrap = m_wrap; x.inc = inc;
        sb_q.push_back(x);
    endtask

    // Assert reset between edges and confirm outputs clear with no clock.
    task automatic async_reset();
        exp_t x;
        @(negedge clk);
        #2 rst = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0;
        #1;
        check("async_rst_bin",  int'(bin_out),  0);
        check("async_rst_gray", int'(gray_out), 0);
        check("async_rst_wrap", int'(wrap),     0);
        m_cnt = 0; m_wrap = 0;
        x.bin = '0; x.gray = '0; x.wrap = 1'b0; x.inc = 0;
        sb_q.push_back(x);
    endtask

    // Monitor: compare every rising edge that has a queued expectation.
    initial begin
        exp_t         x;
        logic [N-1:0] prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("bin_out",  int'(bin_out),  int'(x.bin));
                check("gray_out", int'(gray_out), int'(x.gray));
                check("wrap",     int'(wrap),     int'(x.wrap));
                check("invariant", int'(gray_out), int'(bin_out ^ (bin_out >> 1)));
                if (x.inc)
                    check("gray_hamming", $countones(gray_out ^ prev_gray), 1);
            end
            prev_gray = gray_out;
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        #1;
        check("reset_bin",  int'(bin_out),  0);
        check("reset_gray", int'(gray_out), 0);
        check("reset_wrap", int'(wrap),     0);

        // Reset held with en high, then first count edge.
        repeat (3) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // Complete the cycle back to 0 (wrap), then once more up to 15 and wrap.
        repeat (15) step(0, 1, 0, 0, 0);
        repeat (16) step(0, 1, 0, 0, 0);
        // Hold.
        repeat (5) step(0, 0, 0, 0, 0);
        // Load with en: no extra increment, then one increment.
        step(0, 1, 0, 1, 5);
        step(0, 1, 0, 0, 0);
        // Priority: from 7, clr+load+en clears.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 10);
        // Load 0 from 15 gives no wrap.
        step(0, 0, 0, 1, 15);
        step(0, 1, 0, 1, 0);
        // Async reset mid-count at 9, then resume from 0.
        step(0, 0, 0, 1, 8);
        step(0, 1, 0, 0, 0);
        async_reset();
        repeat (3) step(0, 1, 0, 0, 0);

        // Randomized controls.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
